// File: rtl/tlb_op_ctrl_pkg.sv
// Shared encodings for the TLB-maintenance sequencer: state codes, op codes and
// per-op CSR write-enable masks.
package tlb_op_ctrl_pkg;

    localparam int unsigned TLB_CODE_BIT = 3;

    localparam logic [TLB_CODE_BIT-1:0] LSOC1K_TLB_TLBP   = 3'd1;
    localparam logic [TLB_CODE_BIT-1:0] LSOC1K_TLB_TLBR   = 3'd2;
    localparam logic [TLB_CODE_BIT-1:0] LSOC1K_TLB_TLBWI  = 3'd3;
    localparam logic [TLB_CODE_BIT-1:0] LSOC1K_TLB_TLBWR  = 3'd4;
    localparam logic [TLB_CODE_BIT-1:0] LSOC1K_TLB_INVTLB = 3'd5;

    typedef enum logic [1:0] {
        TOC_IDLE,
        TOC_REQ,
        TOC_WAIT,
        TOC_WB
    } toc_state_e;

    // Mask bit order: {asid, entrylo1, entrylo0, entryhi, index}
    localparam logic [4:0] WE_MASK_NONE = 5'b00000;
    localparam logic [4:0] WE_MASK_TLBP = 5'b00001;
    localparam logic [4:0] WE_MASK_TLBR = 5'b11111;

    function automatic logic [4:0] op_we_mask(input logic [TLB_CODE_BIT-1:0] op);
        case (op)
            LSOC1K_TLB_TLBP: return WE_MASK_TLBP;
            LSOC1K_TLB_TLBR: return WE_MASK_TLBR;
            default:         return WE_MASK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/tlb_op_ctrl.sv
// Sequences one TLB-maintenance op through the tlb_wrapper handshake, stalls EX
// while busy, writes back CSR results and times out hung requests.
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int unsigned GRLEN   = 32,
    parameter int unsigned OPBITS  = TLB_CODE_BIT,
    parameter int unsigned TO_BITS = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ex_valid,
    input  logic [OPBITS-1:0] ex_tlb_op,
    input  logic [4:0]        ex_inv_op,
    input  logic [9:0]        ex_inv_asid,
    input  logic [31:0]       ex_inv_vaddr,
    input  logic              ex_flush,
    output logic              ex_stall,
    output logic              ex_done,
    output logic              tlb_req,
    output logic [OPBITS-1:0] tlb_op,
    output logic [4:0]        c_op,
    output logic [GRLEN-1:0]  inv_asid,
    output logic [31:0]       invtlb_vaddr,
    input  logic              tlb_recv,
    input  logic              tlb_finish,
    input  logic [GRLEN-1:0]  res_index,
    input  logic [GRLEN-1:0]  res_entryhi,
    input  logic [GRLEN-1:0]  res_entrylo0,
    input  logic [GRLEN-1:0]  res_entrylo1,
    input  logic [GRLEN-1:0]  res_asid,
    output logic [GRLEN-1:0]  csr_wdata_index,
    output logic [GRLEN-1:0]  csr_wdata_entryhi,
    output logic [GRLEN-1:0]  csr_wdata_entrylo0,
    output logic [GRLEN-1:0]  csr_wdata_entrylo1,
    output logic [GRLEN-1:0]  csr_wdata_asid,
    output logic              csr_we_index,
    output logic              csr_we_entryhi,
    output logic              csr_we_entrylo0,
    output logic              csr_we_entrylo1,
    output logic              csr_we_asid,
    output logic              tlb_timeout
);

    toc_state_e          state_q, state_d;
    logic [OPBITS-1:0]   op_q;
    logic [4:0]          c_op_q;
    logic [9:0]          asid_q;
    logic [31:0]         vaddr_q;
    logic [TO_BITS-1:0]  wd_q;
    logic                latch, capture, wb;
    logic [4:0]          we_mask;

    always_comb begin
        state_d     = state_q;
        latch       = 1'b0;
        capture     = 1'b0;
        wb          = 1'b0;
        tlb_req     = 1'b0;
        tlb_timeout = 1'b0;
        ex_done     = 1'b0;
        unique case (state_q)
            TOC_IDLE: begin
                if (ex_valid && !ex_flush) begin
                    latch   = 1'b1;
                    state_d = TOC_REQ;
                end
            end
            TOC_REQ: begin
                tlb_req = 1'b1;
                // Acceptance wins over a same-cycle kill: the wrapper owns the op now.
                if (tlb_recv) begin
                    state_d = TOC_WAIT;
                end else if (ex_flush) begin
                    state_d = TOC_IDLE;
                end
            end
            TOC_WAIT: begin
                if (tlb_finish) begin
                    capture = 1'b1;
                    state_d = TOC_WB;
                end else if (&wd_q) begin
                    tlb_timeout = 1'b1;
                    ex_done     = 1'b1;
                    state_d     = TOC_IDLE;
                end
            end
            TOC_WB: begin
                wb      = 1'b1;
                ex_done = 1'b1;
                state_d = TOC_IDLE;
            end
            default: state_d = TOC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q            <= TOC_IDLE;
            op_q               <= '0;
            c_op_q             <= '0;
            asid_q             <= '0;
            vaddr_q            <= '0;
            wd_q               <= '0;
            csr_wdata_index    <= '0;
            csr_wdata_entryhi  <= '0;
            csr_wdata_entrylo0 <= '0;
            csr_wdata_entrylo1 <= '0;
            csr_wdata_asid     <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                op_q    <= ex_tlb_op;
                c_op_q  <= ex_inv_op;
                asid_q  <= ex_inv_asid;
                vaddr_q <= ex_inv_vaddr;
            end
            if (state_q == TOC_REQ) begin
                wd_q <= '0;
            end else if (state_q == TOC_WAIT) begin
                wd_q <= wd_q + TO_BITS'(1);
            end
            if (capture) begin
                csr_wdata_index    <= res_index;
                csr_wdata_entryhi  <= res_entryhi;
                csr_wdata_entrylo0 <= res_entrylo0;
                csr_wdata_entrylo1 <= res_entrylo1;
                csr_wdata_asid     <= res_asid;
            end
        end
    end

    assign we_mask         = op_we_mask(TLB_CODE_BIT'(op_q));
    assign csr_we_index    = wb & we_mask[0];
    assign csr_we_entryhi  = wb & we_mask[1];
    assign csr_we_entrylo0 = wb & we_mask[2];
    assign csr_we_entrylo1 = wb & we_mask[3];
    assign csr_we_asid     = wb & we_mask[4];

    assign tlb_op       = op_q;
    assign c_op         = c_op_q;
    assign inv_asid     = {{(GRLEN-10){1'b0}}, asid_q};
    assign invtlb_vaddr = vaddr_q;
    assign ex_stall     = ex_valid & ~ex_done;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: per-op timelines derived from the handshake rules,
// checked every cycle, plus literal pins on latency and timeout position.
module tb_tlb_op_ctrl;
    import tlb_op_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_valid, ex_flush;
    logic [2:0]  ex_tlb_op;
    logic [4:0]  ex_inv_op;
    logic [9:0]  ex_inv_asid;
    logic [31:0] ex_inv_vaddr;
    logic        ex_stall, ex_done, tlb_req, tlb_timeout;
    logic [2:0]  tlb_op;
    logic [4:0]  c_op;
    logic [31:0] inv_asid, invtlb_vaddr;
    logic        tlb_recv, tlb_finish;
    logic [31:0] res_index, res_entryhi, res_entrylo0, res_entrylo1, res_asid;
    logic [31:0] csr_wdata_index, csr_wdata_entryhi, csr_wdata_entrylo0;
    logic [31:0] csr_wdata_entrylo1, csr_wdata_asid;
    logic        csr_we_index, csr_we_entryhi, csr_we_entrylo0, csr_we_entrylo1, csr_we_asid;

    tlb_op_ctrl #(.GRLEN(32), .OPBITS(3), .TO_BITS(6)) dut (
        .clk(clk), .resetn(resetn),
        .ex_valid(ex_valid), .ex_tlb_op(ex_tlb_op), .ex_inv_op(ex_inv_op),
        .ex_inv_asid(ex_inv_asid), .ex_inv_vaddr(ex_inv_vaddr), .ex_flush(ex_flush),
        .ex_stall(ex_stall), .ex_done(ex_done), .tlb_req(tlb_req), .tlb_op(tlb_op),
        .c_op(c_op), .inv_asid(inv_asid), .invtlb_vaddr(invtlb_vaddr),
        .tlb_recv(tlb_recv), .tlb_finish(tlb_finish),
        .res_index(res_index), .res_entryhi(res_entryhi), .res_entrylo0(res_entrylo0),
        .res_entrylo1(res_entrylo1), .res_asid(res_asid),
        .csr_wdata_index(csr_wdata_index), .csr_wdata_entryhi(csr_wdata_entryhi),
        .csr_wdata_entrylo0(csr_wdata_entrylo0), .csr_wdata_entrylo1(csr_wdata_entrylo1),
        .csr_wdata_asid(csr_wdata_asid),
        .csr_we_index(csr_we_index), .csr_we_entryhi(csr_we_entryhi),
        .csr_we_entrylo0(csr_we_entrylo0), .csr_we_entrylo1(csr_we_entrylo1),
        .csr_we_asid(csr_we_asid), .tlb_timeout(tlb_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected-value state, written by the stimulus side, read by the compare process.
    bit          chk_en = 0;
    int          cur_c;
    logic        exp_req, exp_done, exp_timeout, exp_wb;
    logic [4:0]  exp_we;
    logic [2:0]  exp_op;
    logic [4:0]  exp_cop;
    logic [9:0]  exp_asid;
    logic [31:0] exp_va;
    logic [31:0] exp_res [5];
    int          obs_done_c, obs_to_c, obs_req_n;

    function automatic logic [4:0] mask_of(input logic [2:0] op);
        if (op == LSOC1K_TLB_TLBP) return 5'b00001;
        if (op == LSOC1K_TLB_TLBR) return 5'b11111;
        return 5'b00000;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("tlb_req", tlb_req, exp_req);
            check("ex_done", ex_done, exp_done);
            check("tlb_timeout", tlb_timeout, exp_timeout);
            check("ex_stall", ex_stall, ex_valid & ~exp_done);
            check("csr_we", {csr_we_asid, csr_we_entrylo1, csr_we_entrylo0,
                             csr_we_entryhi, csr_we_index}, exp_we);
            if (exp_req) begin
                check("tlb_op", tlb_op, exp_op);
                check("c_op", c_op, exp_cop);
                check("inv_asid", inv_asid, {22'b0, exp_asid});
                check("invtlb_vaddr", invtlb_vaddr, exp_va);
            end
            if (exp_wb) begin
                check("wdata_index", csr_wdata_index, exp_res[0]);
                check("wdata_entryhi", csr_wdata_entryhi, exp_res[1]);
                check("wdata_entrylo0", csr_wdata_entrylo0, exp_res[2]);
                check("wdata_entrylo1", csr_wdata_entrylo1, exp_res[3]);
                check("wdata_asid", csr_wdata_asid, exp_res[4]);
            end
            if (ex_done) obs_done_c = cur_c;
            if (tlb_timeout) obs_to_c = cur_c;
            if (tlb_req) obs_req_n++;
        end
    end

    // One op from ex_valid (cycle 0) through one trailing idle cycle. Negative cycle
    // arguments mean "never". Operand inputs go to junk after cycle 0 so latching shows.
    task automatic run_op(input logic [2:0] op, input logic [4:0] cop, input logic [9:0] asid,
                          input logic [31:0] va, input int recv_c, input int fin_c,
                          input int flush_c, input int stray_c, input logic [31:0] r0,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] r3,
                          input logic [31:0] r4);
        bit flushed, finished;
        int end_c;
        flushed  = (flush_c >= 0) && (flush_c < recv_c);
        finished = !flushed && (fin_c > recv_c);
        if (flushed)       end_c = flush_c + 1;
        else if (finished) end_c = fin_c + 1;
        else               end_c = recv_c + 64;
        exp_op = op; exp_cop = cop; exp_asid = asid; exp_va = va;
        exp_res[0] = r0; exp_res[1] = r1; exp_res[2] = r2; exp_res[3] = r3; exp_res[4] = r4;
        obs_done_c = -1; obs_to_c = -1; obs_req_n = 0;
        for (int c = 0; c <= end_c + 1; c++) begin
            cur_c        = c;
            ex_valid     = flushed ? (c <= flush_c) : (c <= end_c);
            ex_flush     = (c == flush_c);
            ex_tlb_op    = (c == 0) ? op : 3'($urandom);
            ex_inv_op    = (c == 0) ? cop : 5'($urandom);
            ex_inv_asid  = (c == 0) ? asid : 10'($urandom);
            ex_inv_vaddr = (c == 0) ? va : $urandom;
            tlb_recv     = !flushed && (c == recv_c);
            tlb_finish   = (c == fin_c) || (c == stray_c);
            res_index    = (c == fin_c) ? r0 : $urandom;
            res_entryhi  = (c == fin_c) ? r1 : $urandom;
            res_entrylo0 = (c == fin_c) ? r2 : $urandom;
            res_entrylo1 = (c == fin_c) ? r3 : $urandom;
            res_asid     = (c == fin_c) ? r4 : $urandom;
            exp_req      = (c >= 1) && (c <= (flushed ? flush_c : recv_c));
            exp_done     = !flushed && (c == end_c);
            exp_timeout  = !flushed && !finished && (c == end_c);
            exp_wb       = finished && (c == end_c);
            exp_we       = exp_wb ? mask_of(op) : 5'b0;
            chk_en       = 1;
            @(posedge clk); #1;
        end
        chk_en     = 0;
        ex_valid   = 0; ex_flush = 0; tlb_recv = 0; tlb_finish = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, tlb_req, 0);
        check({tag, "_done"}, ex_done, 0);
        check({tag, "_stall"}, ex_stall, 0);
        check({tag, "_timeout"}, tlb_timeout, 0);
        check({tag, "_we"}, {csr_we_asid, csr_we_entrylo1, csr_we_entrylo0,
                             csr_we_entryhi, csr_we_index}, 0);
        check({tag, "_op"}, {tlb_op, c_op}, 0);
        check({tag, "_asid_va"}, {inv_asid, invtlb_vaddr}, 0);
        check({tag, "_wdata_a"}, {csr_wdata_index, csr_wdata_entryhi}, 0);
        check({tag, "_wdata_b"}, {csr_wdata_entrylo0, csr_wdata_entrylo1}, 0);
        check({tag, "_wdata_c"}, csr_wdata_asid, 0);
    endtask

    initial begin
        resetn = 0; ex_valid = 0; ex_flush = 0; ex_tlb_op = 0; ex_inv_op = 0;
        ex_inv_asid = 0; ex_inv_vaddr = 0; tlb_recv = 0; tlb_finish = 0;
        res_index = 0; res_entryhi = 0; res_entrylo0 = 0; res_entrylo1 = 0; res_asid = 0;
        #2;
        check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        resetn = 1;
        @(posedge clk); #1;

        // TLBR: recv@1 finish@3 -> all five writes and done at 4.
        run_op(LSOC1K_TLB_TLBR, 5'd0, 10'd0, 32'd0, 1, 3, -1, -1,
               32'h0000_0007, 32'h0040_2000, 32'h0001_234F, 32'h0005_678F, 32'h0000_0033);
        check("tlbr_done_cycle", obs_done_c, 4);
        check("tlbr_entryhi_lit", csr_wdata_entryhi, 32'h0040_2000);

        // TLBP: index only.
        run_op(LSOC1K_TLB_TLBP, 5'd0, 10'd0, 32'd0, 1, 3, -1, -1,
               32'h8000_0005, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 32'hAAAA_0004);
        check("tlbp_index_lit", csr_wdata_index, 32'h8000_0005);

        // INVTLB with slower recv and a stray finish while still in REQ.
        run_op(LSOC1K_TLB_INVTLB, 5'd5, 10'h2A, 32'h1234_6000, 2, 5, -1, 1,
               32'h1, 32'h2, 32'h3, 32'h4, 32'h5);
        check("invtlb_req_cycles", obs_req_n, 2);
        check("invtlb_done_cycle", obs_done_c, 6);
        check("invtlb_operands_lit", {c_op, inv_asid, invtlb_vaddr},
              {5'd5, 32'h0000_002A, 32'h1234_6000});

        // Flush in REQ without recv -> dropped.
        run_op(LSOC1K_TLB_TLBR, 5'd0, 10'd0, 32'd0, 3, 5, 2, -1,
               32'h11, 32'h22, 32'h33, 32'h44, 32'h55);
        check("flush_no_done", obs_done_c, -1);

        // Flush same cycle as recv -> completes.
        run_op(LSOC1K_TLB_TLBWI, 5'd0, 10'd0, 32'd0, 1, 4, 1, -1,
               32'h66, 32'h77, 32'h88, 32'h99, 32'hAA);
        check("flush_recv_done_cycle", obs_done_c, 5);

        // Unknown op: done, no writes.
        run_op(3'd7, 5'd0, 10'd0, 32'd0, 1, 2, -1, -1,
               32'hBB, 32'hCC, 32'hDD, 32'hEE, 32'hFF);

        // No finish: timeout 63 cycles after WAIT entry at cycle 2.
        run_op(LSOC1K_TLB_TLBWR, 5'd0, 10'd0, 32'd0, 1, -1, -1, -1,
               32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        check("timeout_cycle", obs_to_c, 65);
        check("timeout_done_cycle", obs_done_c, 65);

        // Async reset during WAIT, then a late finish must be ignored.
        ex_valid = 1; ex_tlb_op = LSOC1K_TLB_TLBR; ex_inv_op = 5'd3;
        ex_inv_asid = 10'h155; ex_inv_vaddr = 32'hDEAD_B000;
        @(posedge clk); #1; tlb_recv = 1;
        @(posedge clk); #1; tlb_recv = 0;
        @(posedge clk); #1;
        resetn = 0; ex_valid = 0;
        #1;
        check_all_zero("midreset");
        @(posedge clk); #1; resetn = 1;
        @(posedge clk); #1;
        exp_req = 0; exp_done = 0; exp_timeout = 0; exp_wb = 0; exp_we = 0;
        tlb_finish = 1; res_index = 32'h1234_5678; res_entryhi = 32'h9ABC_DEF0;
        chk_en = 1;
        @(posedge clk); #1; tlb_finish = 0;
        @(posedge clk); #1; chk_en = 0;
        check("late_finish_wdata", {csr_wdata_index, csr_wdata_entryhi}, 64'h0);

        // Next op after reset completes normally.
        run_op(LSOC1K_TLB_TLBP, 5'd0, 10'd0, 32'd0, 1, 3, -1, -1,
               32'h0000_0009, 32'h1, 32'h2, 32'h3, 32'h4);
        check("post_reset_done_cycle", obs_done_c, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
